bcd_convert_sched: RTL and testbench
====================================

Name: bcd_convert_sched

Overview:
- Sequential, time-shared binary-to-BCD conversion engine for the calculator display path.
- Two requesters share one iterative double-dabble datapath that processes one bit per clock: port 0 is operand entry, port 1 is the ALU result.
- Round-robin arbitration grants the engine to one requester at a time.
- Delivers a 16-digit packed BCD result with significant-digit count and overflow flag to the display driver.

Parameters:
- BIN_W, 54, binary operand width; also the number of SHIFT cycles.
- DIGITS, 16, BCD digits produced; bcd width = 4*DIGITS.
- CNT_W, 6, width of shift counter; must hold BIN_W.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  synchronous, active-high reset.
- req  in  2  level request per requester, held until its done pulse.
- bin0  in  BIN_W  requester-0 unsigned operand; must be stable while req[0]=1.
- bin1  in  BIN_W  requester-1 unsigned operand; must be stable while req[1]=1.
- busy  out  1  high in LOAD-committed/SHIFT/DONE states.
- grant_id  out  1  requester currently owning the engine; valid while busy.
- done  out  1  one-cycle pulse; result valid.
- done_id  out  1  requester the result belongs to; valid with done.
- bcd  out  4*DIGITS  packed BCD result, digit 0 in [3:0]; held until next done.
- n_digits  out  5  significant digits, 1..16 (value 0 reports 1).
- ovf  out  1  operand >= 10^16; held with bcd.

Behaviour:
- Interface: one clock `clk`; reset `reset_p` is synchronous and active-high.
- Reset values: busy=0, grant_id=0, done=0, done_id=0, bcd=0, n_digits=1, ovf=0, state=IDLE, rr pointer favours requester 0.
- IDLE:
  - If any req is high at the clock edge, the arbiter picks a winner.
  - The winner's operand is captured into the shift register; scratch BCD clears; counter clears.
  - ovf_next = (operand >= 10^16); grant_id = winner; next state SHIFT.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester not granted last time wins. After reset, requester 0 wins the first tie.
- SHIFT, per cycle:
  - Every scratch nibble > 4 gets +3 (4-bit wrap never occurs, max 12).
  - Then {scratch, operand} shifts left by 1. Operand MSB enters scratch bit 0.
  - Counter increments. After BIN_W shifts, next state is DONE.
- Entering DONE (same edge):
  - If ovf_next=0: bcd <= scratch. If ovf_next=1: bcd <= 0.
  - ovf <= ovf_next.
  - n_digits <= index of highest nonzero nibble + 1, minimum 1; forced to 16 when ovf.
  - done_id <= grant_id.
- DONE: done=1 for exactly one cycle, then IDLE. No new grant during DONE.
- Latency: req seen in IDLE at cycle c0 → SHIFT c1..c54 → done high in cycle c55 (55 cycles).
- Back-to-back throughput: one conversion per 56 cycles.
- Requester handshake: the requester deasserts req in the cycle after it sees done with a matching done_id. If req is still high when the engine returns to IDLE, a new conversion starts.
- Req drop mid-conversion: the conversion completes and done still pulses; the requester discards the result.
- Operand change after grant: no effect; the operand was captured at grant.
- Reset mid-conversion: abort immediately. All outputs return to reset values; no done pulse.
- Operand 0: bcd=0, n_digits=1, ovf=0.
- Operand 10^16-1: all nines, n_digits=16, ovf=0.

Decomposition:
- Shared package calc_pkg:
  - BIN_W, DIGITS constants.
  - TEN_POW_16 = 54'h2386F26FC10000.
  - State enum {IDLE, SHIFT, DONE}.
- One sub-module, dabble_step: combinational add-3-per-nibble plus 1-bit shift of scratch||operand. It is instantiated once and the scheduler loops it over cycles.
- Arbiter, digit counter and FSM stay in the top.

Test Plan:
- req=01, bin0=123456789 → done in cycle 55 after req, done_id=0, bcd=64'h0000000123456789, n_digits=9, ovf=0.
- req=11 from reset, bin0=5, bin1=42:
  - requester 0 served first: bcd=5, n_digits=1.
  - requester 1 granted 1 cycle after its done (DONE→IDLE, then grant): done_id=1, bcd=64'h42, n_digits=2. Second done 56 cycles after first.
- bin1=10^16-1 → bcd=64'h9999999999999999, n_digits=16, ovf=0.
- bin1=10^16 → bcd=0, n_digits=16, ovf=1.
- bin1=2^54-1 → bcd=0, n_digits=16, ovf=1.
- reset_p pulsed at SHIFT cycle 20 of bin0=999 → no done pulse, outputs at reset values. With req[0] still high, a fresh conversion yields 64'h999 exactly 55 cycles after reset release.
- bin0=0 → bcd=0, n_digits=1. Change bin0 to 7 one cycle after grant → result still 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and FSM state type for the BCD conversion engine.
package calc_pkg;
  localparam int BIN_W  = 54;
  localparam int DIGITS = 16;
  localparam int CNT_W  = 6;

  // Operands at or above this value do not fit in DIGITS decimal digits.
  localparam logic [53:0] TEN_POW_16 = 54'h2386F26FC10000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: add 3 to every nibble above 4, then shift
// {scratch, operand} left by one bit.
module dabble_step
  import calc_pkg::*;
#(
  parameter int BIN_W  = calc_pkg::BIN_W,
  parameter int DIGITS = calc_pkg::DIGITS
) (
  input  logic [4*DIGITS-1:0] scratch,
  input  logic [BIN_W-1:0]    operand,
  output logic [4*DIGITS-1:0] scratch_next,
  output logic [BIN_W-1:0]    operand_next
);
  logic [DIGITS-1:0][3:0] adj;
  logic [4*DIGITS-1:0]    adj_flat;

  // Per-nibble correction; a nibble is at most 9 here, so +3 never wraps.
  for (genvar d = 0; d < DIGITS; d++) begin : g_nib
    assign adj[d] = (scratch[4*d +: 4] > 4'd4) ? scratch[4*d +: 4] + 4'd3
                                               : scratch[4*d +: 4];
  end

  assign adj_flat     = adj;
  assign scratch_next = {adj_flat[4*DIGITS-2:0], operand[BIN_W-1]};
  assign operand_next = {operand[BIN_W-2:0], 1'b0};
endmodule

// File: rtl/bcd_convert_sched.sv
// Two-requester, round-robin scheduled binary-to-BCD converter. One
// dabble_step datapath is reused for BIN_W cycles per conversion.
module bcd_convert_sched
  import calc_pkg::*;
#(
  parameter int BIN_W  = calc_pkg::BIN_W,
  parameter int DIGITS = calc_pkg::DIGITS,
  parameter int CNT_W  = calc_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic [1:0]          req,
  input  logic [BIN_W-1:0]    bin0,
  input  logic [BIN_W-1:0]    bin1,
  output logic                busy,
  output logic                grant_id,
  output logic                done,
  output logic                done_id,
  output logic [4*DIGITS-1:0] bcd,
  output logic [4:0]          n_digits,
  output logic                ovf
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t              state, nstate;
  logic [BIN_W-1:0]    opnd, opnd_nx, win_op;
  logic [4*DIGITS-1:0] scratch, scratch_nx;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_next;
  logic                prio;      // requester favoured on a tie
  logic                win;
  logic [4:0]          nd_nx;

  dabble_step #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_step (
    .scratch      (scratch),
    .operand      (opnd),
    .scratch_next (scratch_nx),
    .operand_next (opnd_nx)
  );

  // Round-robin pick: a lone requester wins, a tie goes to prio.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = prio;
      default: win = 1'b0;
    endcase
    win_op = win ? bin1 : bin0;
  end

  // Significant digits of the final scratch value (0 reports 1).
  always_comb begin
    nd_nx = 5'd1;
    for (int i = 0; i < DIGITS; i++)
      if (scratch_nx[4*i +: 4] != 4'd0) nd_nx = 5'(i + 1);
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (|req) nstate = SHIFT;
      SHIFT:   if (cnt == LAST) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_p) state <= IDLE;
    else         state <= nstate;
  end

  // Datapath: capture on grant, shift in SHIFT, publish result entering DONE.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      opnd     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      grant_id <= 1'b0;
      prio     <= 1'b0;
      bcd      <= '0;
      n_digits <= 5'd1;
      ovf      <= 1'b0;
      done_id  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          opnd     <= win_op;
          scratch  <= '0;
          cnt      <= '0;
          ovf_next <= (win_op >= TEN_POW_16);
          grant_id <= win;
          prio     <= ~win;
        end
        SHIFT: begin
          opnd    <= opnd_nx;
          scratch <= scratch_nx;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd      <= ovf_next ? '0 : scratch_nx;
            ovf      <= ovf_next;
            n_digits <= ovf_next ? 5'(DIGITS) : nd_nx;
            done_id  <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_bcd_convert_sched.sv
// Directed test of bcd_convert_sched: latency, arbitration, overflow,
// reset abort and operand capture.
module tb_bcd_convert_sched;
  logic        clk = 1'b0;
  logic        reset_p;
  logic [1:0]  req;
  logic [53:0] bin0, bin1;
  logic        busy, grant_id, done, done_id, ovf;
  logic [63:0] bcd;
  logic [4:0]  n_digits;
  int          total = 0;
  int          passed = 0;
  int          n;

  always #5 clk = ~clk;

  bcd_convert_sched dut (
    .clk(clk), .reset_p(reset_p), .req(req), .bin0(bin0), .bin1(bin1),
    .busy(busy), .grant_id(grant_id), .done(done), .done_id(done_id),
    .bcd(bcd), .n_digits(n_digits), .ovf(ovf)
  );

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Count edges until done is seen; bounded so a dead DUT still finishes.
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!done && cnt < 200);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset_p = 1'b1; req = 2'b00; bin0 = '0; bin1 = '0;
    step(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", bcd, 64'd0);
    chk("rst_nd", 64'(n_digits), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    reset_p = 1'b0;

    // Tie from reset: requester 0 first, then requester 1.
    bin0 = 54'd5; bin1 = 54'd42; req = 2'b11;
    wait_done(n);
    chk("tie_lat0", 64'(n), 64'd55);
    chk("tie_id0", 64'(done_id), 64'd0);
    chk("tie_bcd0", bcd, 64'h5);
    chk("tie_nd0", 64'(n_digits), 64'd1);
    req = 2'b10;
    wait_done(n);
    chk("tie_lat1", 64'(n), 64'd56);
    chk("tie_id1", 64'(done_id), 64'd1);
    chk("tie_bcd1", bcd, 64'h42);
    chk("tie_nd1", 64'(n_digits), 64'd2);
    req = 2'b00;
    step(1);
    chk("done_pulse", 64'(done), 64'd0);
    chk("bcd_hold", bcd, 64'h42);

    // Single requester 0.
    bin0 = 54'd123456789; req = 2'b01;
    wait_done(n);
    chk("r0_lat", 64'(n), 64'd55);
    chk("r0_id", 64'(done_id), 64'd0);
    chk("r0_bcd", bcd, 64'h0000000123456789);
    chk("r0_nd", 64'(n_digits), 64'd9);
    chk("r0_ovf", 64'(ovf), 64'd0);
    req = 2'b00; step(1);

    // Largest representable value: all nines.
    bin1 = 54'h2386F26FC0FFFF; req = 2'b10;
    wait_done(n);
    chk("max_bcd", bcd, 64'h9999999999999999);
    chk("max_nd", 64'(n_digits), 64'd16);
    chk("max_ovf", 64'(ovf), 64'd0);
    req = 2'b00; step(1);

    // Exactly 10^16 overflows.
    bin1 = 54'h2386F26FC10000; req = 2'b10;
    wait_done(n);
    chk("p16_bcd", bcd, 64'd0);
    chk("p16_nd", 64'(n_digits), 64'd16);
    chk("p16_ovf", 64'(ovf), 64'd1);
    req = 2'b00; step(1);

    // All ones overflows.
    bin1 = '1; req = 2'b10;
    wait_done(n);
    chk("ones_bcd", bcd, 64'd0);
    chk("ones_nd", 64'(n_digits), 64'd16);
    chk("ones_ovf", 64'(ovf), 64'd1);
    chk("ones_id", 64'(done_id), 64'd1);
    req = 2'b00; step(1);

    // Reset in SHIFT cycle 20 aborts; conversion restarts after release.
    bin0 = 54'd999; req = 2'b01;
    step(21);
    chk("abort_busy", 64'(busy), 64'd1);
    reset_p = 1'b1;
    step(1);
    chk("abort_busy0", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    chk("abort_nd", 64'(n_digits), 64'd1);
    chk("abort_did", 64'(done_id), 64'd0);
    chk("abort_gid", 64'(grant_id), 64'd0);
    reset_p = 1'b0;
    wait_done(n);
    chk("restart_lat", 64'(n), 64'd55);
    chk("restart_bcd", bcd, 64'h999);
    chk("restart_nd", 64'(n_digits), 64'd3);
    req = 2'b00; step(1);

    // Zero operand; later operand change must not matter.
    bin0 = 54'd0; req = 2'b01;
    step(1);
    chk("zero_busy", 64'(busy), 64'd1);
    bin0 = 54'd7;
    wait_done(n);
    chk("zero_lat", 64'(n), 64'd54);
    chk("zero_bcd", bcd, 64'd0);
    chk("zero_nd", 64'(n_digits), 64'd1);
    chk("zero_ovf", 64'(ovf), 64'd0);
    req = 2'b00; step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
